midi_src_arbiter: RTL and testbench
===================================

// Module: midi_src_arbiter
// PURPOSE
//  Shares the single MIDI byte path into the synth controller (byteready / midibyte_nr /
//  midi_in_data consumed by the sequencer trigger stage) between NUM_SRC byte producers
//  (DIN UART rx, HPS/USB MIDI, auto sysex patch generator). Arbitrates round-robin at MIDI
//  message boundaries only, so messages are never interleaved. Numbers bytes within a
//  message and paces output so the 4-stage trigger pipeline drains between bytes.
// PARAMETERS
//  NUM_SRC      3     number of requesting byte sources (2..8)
//  GAP_CYCLES   6     min reg_clk cycles from one byteready pulse to the next (>=5)
//  TIMEOUT      4096  max cycles a granted source may stall mid-message before abort
// PORTS
//  reg_clk        in   1          system register clock
//  reset_reg      in   1          asynchronous reset, active high
//  src_valid      in   NUM_SRC    per-source byte valid; held with data until accepted
//  src_data       in   8*NUM_SRC  per-source byte, source i at [8*i+7:8*i]
//  src_ready      out  NUM_SRC    one-hot accept strobe; byte taken when valid & ready
//  byteready      out  1          1-cycle pulse: new byte on midi_in_data
//  midi_in_data   out  8          forwarded byte, held until next byteready
//  midibyte_nr    out  8          byte index in message: 0 = status, 1.. = data bytes
//  grant_id       out  3          index of currently granted source
//  busy           out  1          high while a message is in progress (state != IDLE)
//  timeout_err    out  1          1-cycle pulse when a stalled message is aborted
// BEHAVIOUR
//  Reset (async, any state): state=IDLE, all outputs 0, rr pointer=0, counters 0.
//  States: IDLE -> FWD -> GAP -> (FWD | IDLE).
//  IDLE: if any src_valid, grant first valid source at/after rr pointer (wrap at NUM_SRC);
//   grant_id updated, go FWD next cycle. No source valid: stay.
//  FWD: src_ready[grant_id]=src_valid[grant_id] (combinational); other ready bits 0.
//   On accept: next cycle byteready=1, midi_in_data=byte, midibyte_nr as below; go GAP.
//  GAP: count GAP_CYCLES-1 cycles after byteready, no ready asserted; then FWD if message
//   incomplete, else IDLE with rr pointer = grant_id+1 (mod NUM_SRC).
//  Message length from status byte: 8x,9x,Ax,Bx,Ex,F2 = 3; Cx,Dx,F1,F3 = 2;
//   F6,F8-FF = 1; F0 = open until F7 (F7 forwarded, ends message); F4,F5 = 1.
//  midibyte_nr: 0 on status, +1 per data byte, saturates at 8'hFF in long sysex.
//  First byte of a grant with bit7=0 (orphan data): forwarded with midibyte_nr=1, message
//   ends (length 1); no running status supported.
//  Realtime byte (F8-FF) mid-message from granted source: forwarded with midibyte_nr=0,
//   message count and expected length unchanged.
//  Non-realtime status byte (bit7=1) where data expected: current message ends, byte
//   treated as new status of the same source (grant kept, midibyte_nr=0).
//  Stall counter runs in FWD while message incomplete and src_valid[grant_id]=0; reaching
//   TIMEOUT: timeout_err pulse, state IDLE, rr advanced. Counter clears on each accept.
//  At most one src_ready bit high per cycle; never asserted in IDLE or GAP.
//  Latency: accept -> byteready exactly 1 cycle; byteready spacing >= GAP_CYCLES.
// TESTING
//  Src0 sends 90 3C 64 -> byteready x3, midibyte_nr 0,1,2, spacing exactly GAP_CYCLES.
//  Src0 and src1 both valid in IDLE (src0: 90 3C 64, src1: C0 05) -> src0 msg complete
//   first, then src1 C0 05; no interleave; third request goes back to src2/src0 per rr.
//  Src2 sends F0 7E 01 ... (300 data) F7 -> midibyte_nr saturates at FF, F7 ends, IDLE.
//  Src0 sends 90 3C, F8, 64 -> F8 out with nr=0, then 64 out with nr=2.
//  Src1 sends B0 07 then stalls -> timeout_err after TIMEOUT cycles, grant passes to src2.
//  Assert reset_reg mid-sysex -> outputs 0 immediately, IDLE, next grant from src0.

Source files
------------

// File: rtl/midi_src_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : midi_src_arbiter
// Description : Shares the single MIDI byte path into the synth controller
//               between NUM_SRC byte producers. Sources are arbitrated
//               round-robin, but only at MIDI message boundaries, so messages
//               never interleave. Bytes are numbered within their message and
//               paced so the downstream trigger pipeline drains between bytes.
// Ports       : reg_clk, reset_reg (async, active high)
//               src_valid/src_data/src_ready : per-source byte handshake
//               byteready/midi_in_data/midibyte_nr : forwarded byte stream
//               grant_id, busy, timeout_err : status
// Revision    : 1.0  initial release
// ============================================================================
module midi_src_arbiter #(
    parameter int NUM_SRC    = 3,
    parameter int GAP_CYCLES = 6,
    parameter int TIMEOUT    = 4096
) (
    input  logic                   reg_clk,
    input  logic                   reset_reg,
    input  logic [NUM_SRC-1:0]     src_valid,
    input  logic [8*NUM_SRC-1:0]   src_data,
    output logic [NUM_SRC-1:0]     src_ready,
    output logic                   byteready,
    output logic [7:0]             midi_in_data,
    output logic [7:0]             midibyte_nr,
    output logic [2:0]             grant_id,
    output logic                   busy,
    output logic                   timeout_err
);

    localparam int c_GAP_W = $clog2(GAP_CYCLES + 1);
    localparam int c_TO_W  = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_FWD  = 2'd1,
        ST_GAP  = 2'd2
    } state_t;

    state_t              r_state;
    logic [2:0]          r_grant;
    logic [2:0]          r_rr;
    logic                r_byteready;
    logic [7:0]          r_data;
    logic [7:0]          r_nr;
    logic                r_timeout;
    logic [c_GAP_W-1:0]  r_gap;
    logic [c_TO_W-1:0]   r_stall;
    logic [7:0]          r_cnt;     // data-byte index, unaffected by realtime bytes
    logic [1:0]          r_rem;     // data bytes still expected (non-sysex)
    logic                r_sysex;
    logic                r_first;   // next byte is the first of this grant
    logic                r_done;    // last accepted byte completed the message

    logic                w_found;
    logic [2:0]          w_pick;
    logic [3:0]          w_idx;
    logic                w_gvalid;
    logic [7:0]          w_byte;
    logic [2:0]          w_next_rr;
    logic [1:0]          w_len;
    logic [7:0]          w_cnt_inc;
    logic [7:0]          w_nr;
    logic [7:0]          w_cnt;
    logic [1:0]          w_rem;
    logic                w_sysex;
    logic                w_done;

    // Total message length implied by a status byte (F0 handled separately).
    function automatic logic [1:0] msg_len(input logic [7:0] b);
        logic [1:0] len;
        case (b[7:4])
            4'h8, 4'h9, 4'hA, 4'hB, 4'hE: len = 2'd3;
            4'hC, 4'hD:                   len = 2'd2;
            4'hF: begin
                case (b[3:0])
                    4'h1, 4'h3: len = 2'd2;
                    4'h2:       len = 2'd3;
                    default:    len = 2'd1;
                endcase
            end
            default:                      len = 2'd1;
        endcase
        return len;
    endfunction

    // Source selection, granted-source mux and accept strobes.
    always_comb begin
        w_found   = 1'b0;
        w_pick    = 3'd0;
        w_idx     = 4'd0;
        w_gvalid  = 1'b0;
        w_byte    = 8'h00;
        src_ready = '0;
        // First valid source at or after the round-robin pointer.
        for (int k = 0; k < NUM_SRC; k++) begin
            w_idx = {1'b0, r_rr} + 4'(k);
            if (w_idx >= 4'(NUM_SRC)) begin
                w_idx = w_idx - 4'(NUM_SRC);
            end
            for (int j = 0; j < NUM_SRC; j++) begin
                if (!w_found && (w_idx == 4'(j)) && src_valid[j]) begin
                    w_found = 1'b1;
                    w_pick  = 3'(j);
                end
            end
        end
        for (int i = 0; i < NUM_SRC; i++) begin
            if (r_grant == 3'(i)) begin
                w_gvalid = src_valid[i];
                w_byte   = src_data[8*i +: 8];
            end
            src_ready[i] = (r_state == ST_FWD) && (r_grant == 3'(i)) && src_valid[i];
        end
    end

    assign w_next_rr = (r_grant == 3'(NUM_SRC - 1)) ? 3'd0 : r_grant + 3'd1;

    // Message tracking update for the byte currently offered by the granted source.
    always_comb begin
        w_len     = msg_len(w_byte);
        w_cnt_inc = (r_cnt == 8'hFF) ? 8'hFF : r_cnt + 8'd1;
        w_nr      = 8'h00;
        w_cnt     = r_cnt;
        w_rem     = r_rem;
        w_sysex   = r_sysex;
        w_done    = 1'b0;
        if (r_first && !w_byte[7]) begin
            // Orphan data byte without a status: forwarded alone as index 1.
            w_nr   = 8'h01;
            w_cnt  = 8'h01;
            w_done = 1'b1;
        end else if (!r_first && (w_byte >= 8'hF8)) begin
            // Realtime byte slipped into a message: index 0, message state untouched.
            w_nr = 8'h00;
        end else if (!r_first && !w_byte[7]) begin
            w_cnt = w_cnt_inc;
            w_nr  = w_cnt_inc;
            if (!r_sysex) begin
                w_rem  = r_rem - 2'd1;
                w_done = (r_rem == 2'd1);
            end
        end else if (!r_first && r_sysex && (w_byte == 8'hF7)) begin
            w_cnt   = w_cnt_inc;
            w_nr    = w_cnt_inc;
            w_sysex = 1'b0;
            w_done  = 1'b1;
        end else begin
            // Status byte: starts a new message from the same source.
            w_nr    = 8'h00;
            w_cnt   = 8'h00;
            w_sysex = (w_byte == 8'hF0);
            w_rem   = w_len - 2'd1;
            w_done  = (w_byte != 8'hF0) && (w_len == 2'd1);
        end
    end

    always_ff @(posedge reg_clk or posedge reset_reg) begin
        if (reset_reg) begin
            r_state     <= ST_IDLE;
            r_grant     <= 3'd0;
            r_rr        <= 3'd0;
            r_byteready <= 1'b0;
            r_data      <= 8'h00;
            r_nr        <= 8'h00;
            r_timeout   <= 1'b0;
            r_gap       <= '0;
            r_stall     <= '0;
            r_cnt       <= 8'h00;
            r_rem       <= 2'd0;
            r_sysex     <= 1'b0;
            r_first     <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_byteready <= 1'b0;
            r_timeout   <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_found) begin
                        r_grant <= w_pick;
                        r_first <= 1'b1;
                        r_sysex <= 1'b0;
                        r_stall <= '0;
                        r_state <= ST_FWD;
                    end
                end
                ST_FWD: begin
                    if (w_gvalid) begin
                        r_byteready <= 1'b1;
                        r_data      <= w_byte;
                        r_nr        <= w_nr;
                        r_cnt       <= w_cnt;
                        r_rem       <= w_rem;
                        r_sysex     <= w_sysex;
                        r_done      <= w_done;
                        r_first     <= 1'b0;
                        r_stall     <= '0;
                        r_gap       <= '0;
                        r_state     <= ST_GAP;
                    end else if (r_stall == c_TO_W'(TIMEOUT - 1)) begin
                        r_timeout <= 1'b1;
                        r_stall   <= '0;
                        r_rr      <= w_next_rr;
                        r_state   <= ST_IDLE;
                    end else begin
                        r_stall <= r_stall + c_TO_W'(1);
                    end
                end
                ST_GAP: begin
                    // GAP_CYCLES-1 cycles here plus the accept cycle give the spacing.
                    if (r_gap == c_GAP_W'(GAP_CYCLES - 2)) begin
                        if (r_done) begin
                            r_rr    <= w_next_rr;
                            r_state <= ST_IDLE;
                        end else begin
                            r_state <= ST_FWD;
                        end
                    end else begin
                        r_gap <= r_gap + c_GAP_W'(1);
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign byteready    = r_byteready;
    assign midi_in_data = r_data;
    assign midibyte_nr  = r_nr;
    assign grant_id     = r_grant;
    assign busy         = (r_state != ST_IDLE);
    assign timeout_err  = r_timeout;

endmodule
`default_nettype wire

// File: tb/tb_midi_src_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_midi_src_arbiter
// Description : Directed self-checking bench for midi_src_arbiter. Each source
//               is modelled as a byte queue; forwarded bytes are logged and
//               compared against hand-written expected streams.
// Revision    : 1.0  initial release
// ============================================================================
module tb_midi_src_arbiter;

    localparam int NUM_SRC = 3;
    localparam int GAP     = 6;
    localparam int TO      = 4096;

    logic                 reg_clk = 1'b0;
    logic                 reset_reg;
    logic [NUM_SRC-1:0]   src_valid;
    logic [8*NUM_SRC-1:0] src_data;
    logic [NUM_SRC-1:0]   src_ready;
    logic                 byteready;
    logic [7:0]           midi_in_data;
    logic [7:0]           midibyte_nr;
    logic [2:0]           grant_id;
    logic                 busy;
    logic                 timeout_err;

    midi_src_arbiter #(.NUM_SRC(NUM_SRC), .GAP_CYCLES(GAP), .TIMEOUT(TO)) dut (
        .reg_clk      (reg_clk),
        .reset_reg    (reset_reg),
        .src_valid    (src_valid),
        .src_data     (src_data),
        .src_ready    (src_ready),
        .byteready    (byteready),
        .midi_in_data (midi_in_data),
        .midibyte_nr  (midibyte_nr),
        .grant_id     (grant_id),
        .busy         (busy),
        .timeout_err  (timeout_err)
    );

    always #5 reg_clk = ~reg_clk;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    int ready_viol = 0;

    logic [7:0] q0[$], q1[$], q2[$];
    logic [7:0] od[$], onr[$];
    logic [2:0] og[$];
    int         ocyc[$], to_cyc[$];
    logic [7:0] ed[$], en[$];
    logic [2:0] eg[$];

    task automatic drive();
        src_valid = {q2.size() != 0, q1.size() != 0, q0.size() != 0};
        src_data  = {(q2.size() != 0) ? q2[0] : 8'h00,
                     (q1.size() != 0) ? q1[0] : 8'h00,
                     (q0.size() != 0) ? q0[0] : 8'h00};
    endtask

    task automatic tick();
        logic [2:0] acc;
        @(negedge reg_clk);
        cyc++;
        if (byteready) begin
            od.push_back(midi_in_data);
            onr.push_back(midibyte_nr);
            og.push_back(grant_id);
            ocyc.push_back(cyc);
        end
        if (timeout_err) to_cyc.push_back(cyc);
        if (!$onehot0(src_ready) || (!busy && src_ready != 0)) ready_viol++;
        acc = src_ready & src_valid;
        @(posedge reg_clk);
        #1;
        if (acc[0]) void'(q0.pop_front());
        if (acc[1]) void'(q1.pop_front());
        if (acc[2]) void'(q2.pop_front());
        drive();
    endtask

    task automatic clear_all();
        od.delete(); onr.delete(); og.delete(); ocyc.delete(); to_cyc.delete();
        ed.delete(); en.delete(); eg.delete();
    endtask

    task automatic wait_idle(input int max, input string name);
        int n = 0;
        while (!(q0.size() == 0 && q1.size() == 0 && q2.size() == 0 && !busy) && n < max) begin
            tick();
            n++;
        end
        checks++;
        if (n >= max) begin
            errors++;
            $display("FAIL %s_idle: still busy=%0b after %0d cycles, required idle", name, busy, max);
        end
    endtask

    task automatic do_reset();
        q0.delete(); q1.delete(); q2.delete();
        drive();
        reset_reg = 1'b1;
        @(posedge reg_clk);
        #1;
        reset_reg = 1'b0;
    endtask

    task automatic test_reset();
        checks += 7;
        if (byteready !== 1'b0)    begin errors++; $display("FAIL reset_byteready: got %0b, required 0", byteready); end
        if (midi_in_data !== 8'h0) begin errors++; $display("FAIL reset_data: got %02h, required 00", midi_in_data); end
        if (midibyte_nr !== 8'h0)  begin errors++; $display("FAIL reset_nr: got %02h, required 00", midibyte_nr); end
        if (grant_id !== 3'd0)     begin errors++; $display("FAIL reset_grant: got %0d, required 0", grant_id); end
        if (busy !== 1'b0)         begin errors++; $display("FAIL reset_busy: got %0b, required 0", busy); end
        if (timeout_err !== 1'b0)  begin errors++; $display("FAIL reset_timeout: got %0b, required 0", timeout_err); end
        if (src_ready !== 3'b000)  begin errors++; $display("FAIL reset_ready: got %03b, required 000", src_ready); end
        repeat (4) tick();
        checks++;
        if (busy !== 1'b0 || od.size() != 0) begin
            errors++;
            $display("FAIL idle_no_req: got busy=%0b bytes=%0d, required busy=0 bytes=0", busy, od.size());
        end
    endtask

    task automatic test_single_msg();
        clear_all();
        q0 = '{8'h90, 8'h3C, 8'h64};
        drive();
        wait_idle(100, "single");
        ed = '{8'h90, 8'h3C, 8'h64}; en = '{8'd0, 8'd1, 8'd2}; eg = '{3'd0, 3'd0, 3'd0};
        checks++;
        if (od.size() != ed.size()) begin errors++; $display("FAIL single_count: got %0d bytes, required %0d", od.size(), ed.size()); end
        for (int i = 0; i < ed.size() && i < od.size(); i++) begin
            checks++;
            if (od[i] !== ed[i] || onr[i] !== en[i] || og[i] !== eg[i]) begin
                errors++;
                $display("FAIL single_byte[%0d]: got data=%02h nr=%0d grant=%0d, required data=%02h nr=%0d grant=%0d",
                         i, od[i], onr[i], og[i], ed[i], en[i], eg[i]);
            end
        end
        for (int i = 1; i < ocyc.size(); i++) begin
            checks++;
            if (ocyc[i] - ocyc[i-1] != GAP) begin
                errors++;
                $display("FAIL single_spacing[%0d]: got %0d cycles, required %0d", i, ocyc[i] - ocyc[i-1], GAP);
            end
        end
    endtask

    task automatic test_rr_arbitration();
        do_reset();
        clear_all();
        q0 = '{8'h90, 8'h3C, 8'h64};
        q1 = '{8'hC0, 8'h05};
        drive();
        wait_idle(200, "rr_first");
        q0 = '{8'hF8};
        q2 = '{8'hF6};
        drive();
        wait_idle(100, "rr_second");
        ed = '{8'h90, 8'h3C, 8'h64, 8'hC0, 8'h05, 8'hF6, 8'hF8};
        en = '{8'd0, 8'd1, 8'd2, 8'd0, 8'd1, 8'd0, 8'd0};
        eg = '{3'd0, 3'd0, 3'd0, 3'd1, 3'd1, 3'd2, 3'd0};
        checks++;
        if (od.size() != ed.size()) begin errors++; $display("FAIL rr_count: got %0d bytes, required %0d", od.size(), ed.size()); end
        for (int i = 0; i < ed.size() && i < od.size(); i++) begin
            checks++;
            if (od[i] !== ed[i] || onr[i] !== en[i] || og[i] !== eg[i]) begin
                errors++;
                $display("FAIL rr_byte[%0d]: got data=%02h nr=%0d grant=%0d, required data=%02h nr=%0d grant=%0d",
                         i, od[i], onr[i], og[i], ed[i], en[i], eg[i]);
            end
        end
    endtask

    task automatic test_realtime_mid();
        clear_all();
        q0 = '{8'h90, 8'h3C, 8'hF8, 8'h64};
        drive();
        wait_idle(100, "rt");
        ed = '{8'h90, 8'h3C, 8'hF8, 8'h64}; en = '{8'd0, 8'd1, 8'd0, 8'd2}; eg = '{3'd0, 3'd0, 3'd0, 3'd0};
        checks++;
        if (od.size() != ed.size()) begin errors++; $display("FAIL rt_count: got %0d bytes, required %0d", od.size(), ed.size()); end
        for (int i = 0; i < ed.size() && i < od.size(); i++) begin
            checks++;
            if (od[i] !== ed[i] || onr[i] !== en[i] || og[i] !== eg[i]) begin
                errors++;
                $display("FAIL rt_byte[%0d]: got data=%02h nr=%0d grant=%0d, required data=%02h nr=%0d grant=%0d",
                         i, od[i], onr[i], og[i], ed[i], en[i], eg[i]);
            end
        end
    endtask

    task automatic test_status_interrupt();
        clear_all();
        q0 = '{8'h90, 8'h3C, 8'hC0, 8'h05};
        drive();
        wait_idle(100, "sint");
        q1 = '{8'h3C};
        drive();
        wait_idle(50, "orphan");
        ed = '{8'h90, 8'h3C, 8'hC0, 8'h05, 8'h3C};
        en = '{8'd0, 8'd1, 8'd0, 8'd1, 8'd1};
        eg = '{3'd0, 3'd0, 3'd0, 3'd0, 3'd1};
        checks++;
        if (od.size() != ed.size()) begin errors++; $display("FAIL sint_count: got %0d bytes, required %0d", od.size(), ed.size()); end
        for (int i = 0; i < ed.size() && i < od.size(); i++) begin
            checks++;
            if (od[i] !== ed[i] || onr[i] !== en[i] || og[i] !== eg[i]) begin
                errors++;
                $display("FAIL sint_byte[%0d]: got data=%02h nr=%0d grant=%0d, required data=%02h nr=%0d grant=%0d",
                         i, od[i], onr[i], og[i], ed[i], en[i], eg[i]);
            end
        end
    endtask

    task automatic test_sysex_long();
        clear_all();
        q2.push_back(8'hF0); ed.push_back(8'hF0); en.push_back(8'd0); eg.push_back(3'd2);
        for (int k = 1; k <= 300; k++) begin
            logic [7:0] b;
            b = (k == 1) ? 8'h7E : (k == 2) ? 8'h01 : 8'(k & 8'h7F);
            q2.push_back(b);
            ed.push_back(b);
            en.push_back((k > 255) ? 8'hFF : 8'(k));
            eg.push_back(3'd2);
        end
        q2.push_back(8'hF7); ed.push_back(8'hF7); en.push_back(8'hFF); eg.push_back(3'd2);
        drive();
        wait_idle(2600, "sysex");
        checks++;
        if (od.size() != ed.size()) begin errors++; $display("FAIL sysex_count: got %0d bytes, required %0d", od.size(), ed.size()); end
        for (int i = 0; i < ed.size() && i < od.size(); i++) begin
            checks++;
            if (od[i] !== ed[i] || onr[i] !== en[i] || og[i] !== eg[i]) begin
                errors++;
                $display("FAIL sysex_byte[%0d]: got data=%02h nr=%0d grant=%0d, required data=%02h nr=%0d grant=%0d",
                         i, od[i], onr[i], og[i], ed[i], en[i], eg[i]);
            end
        end
    endtask

    task automatic test_timeout();
        int n;
        clear_all();
        q1 = '{8'hB0, 8'h07};
        drive();
        n = 0;
        while (od.size() < 2 && n < 50) begin tick(); n++; end
        q0 = '{8'hF6};
        q2 = '{8'hF6};
        drive();
        n = 0;
        while (to_cyc.size() == 0 && n < TO + 100) begin tick(); n++; end
        checks++;
        if (to_cyc.size() == 0 || od.size() < 2) begin
            errors++;
            $display("FAIL timeout_seen: got %0d pulses, required 1", to_cyc.size());
        end else begin
            checks++;
            if (to_cyc[0] - ocyc[1] != GAP + TO - 1) begin
                errors++;
                $display("FAIL timeout_delay: got %0d cycles, required %0d", to_cyc[0] - ocyc[1], GAP + TO - 1);
            end
        end
        checks++;
        if (timeout_err !== 1'b0 || grant_id !== 3'd2) begin
            errors++;
            $display("FAIL timeout_after: got err=%0b grant=%0d, required err=0 grant=2", timeout_err, grant_id);
        end
        wait_idle(100, "timeout");
        checks++;
        if (to_cyc.size() != 1) begin errors++; $display("FAIL timeout_pulses: got %0d, required 1", to_cyc.size()); end
        ed = '{8'hB0, 8'h07, 8'hF6, 8'hF6}; en = '{8'd0, 8'd1, 8'd0, 8'd0}; eg = '{3'd1, 3'd1, 3'd2, 3'd0};
        checks++;
        if (od.size() != ed.size()) begin errors++; $display("FAIL timeout_count: got %0d bytes, required %0d", od.size(), ed.size()); end
        for (int i = 0; i < ed.size() && i < od.size(); i++) begin
            checks++;
            if (od[i] !== ed[i] || onr[i] !== en[i] || og[i] !== eg[i]) begin
                errors++;
                $display("FAIL timeout_byte[%0d]: got data=%02h nr=%0d grant=%0d, required data=%02h nr=%0d grant=%0d",
                         i, od[i], onr[i], og[i], ed[i], en[i], eg[i]);
            end
        end
    endtask

    task automatic test_reset_mid_sysex();
        int n;
        clear_all();
        q2.push_back(8'hF0);
        for (int k = 0; k < 20; k++) q2.push_back(8'h11 + 8'(k));
        drive();
        n = 0;
        while (od.size() < 3 && n < 100) begin tick(); n++; end
        checks++;
        if (busy !== 1'b1 || midibyte_nr !== 8'd2) begin
            errors++;
            $display("FAIL rstmid_pre: got busy=%0b nr=%0d, required busy=1 nr=2", busy, midibyte_nr);
        end
        reset_reg = 1'b1;
        #1;
        checks += 2;
        if (midi_in_data !== 8'h00 || midibyte_nr !== 8'h00 || byteready !== 1'b0) begin
            errors++;
            $display("FAIL rstmid_data: got data=%02h nr=%0d br=%0b, required all 0", midi_in_data, midibyte_nr, byteready);
        end
        if (grant_id !== 3'd0 || busy !== 1'b0 || timeout_err !== 1'b0) begin
            errors++;
            $display("FAIL rstmid_state: got grant=%0d busy=%0b err=%0b, required all 0", grant_id, busy, timeout_err);
        end
        q0.delete(); q1.delete(); q2.delete();
        drive();
        @(posedge reg_clk);
        #1;
        reset_reg = 1'b0;
        clear_all();
        q0 = '{8'hF6};
        q1 = '{8'hF6};
        drive();
        wait_idle(100, "rstmid");
        ed = '{8'hF6, 8'hF6}; en = '{8'd0, 8'd0}; eg = '{3'd0, 3'd1};
        checks++;
        if (od.size() != ed.size()) begin errors++; $display("FAIL rstmid_count: got %0d bytes, required %0d", od.size(), ed.size()); end
        for (int i = 0; i < ed.size() && i < od.size(); i++) begin
            checks++;
            if (od[i] !== ed[i] || onr[i] !== en[i] || og[i] !== eg[i]) begin
                errors++;
                $display("FAIL rstmid_byte[%0d]: got data=%02h nr=%0d grant=%0d, required data=%02h nr=%0d grant=%0d",
                         i, od[i], onr[i], og[i], ed[i], en[i], eg[i]);
            end
        end
    endtask

    initial begin
        reset_reg = 1'b1;
        drive();
        repeat (3) @(posedge reg_clk);
        #1;
        reset_reg = 1'b0;
        test_reset();
        test_single_msg();
        test_rr_arbitration();
        test_realtime_mid();
        test_status_interrupt();
        test_sysex_long();
        test_timeout();
        test_reset_mid_sysex();
        checks++;
        if (ready_viol != 0) begin
            errors++;
            $display("FAIL ready_onehot: got %0d violating cycles, required 0", ready_viol);
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
